// File: rtl/patt_gen_multi_pkg.sv
// Shared pattern-generator definitions: pattern mode codes and 3-bit colour codes.
// No logic; imported by the generator, its scroll controller and sync/overlay blocks.
// Colour code bit order is {R,G,B}.
package patt_pkg;

    typedef enum logic [2:0] {
        MODE_HBARS   = 3'd0,
        MODE_VBARS   = 3'd1,
        MODE_CHECKER = 3'd2,
        MODE_SCROLL  = 3'd3,
        MODE_SOLID   = 3'd4
    } mode_e;

    localparam logic [2:0] BLACK  = 3'd0;
    localparam logic [2:0] BLUE   = 3'd1;
    localparam logic [2:0] GREEN  = 3'd2;
    localparam logic [2:0] CYAN   = 3'd3;
    localparam logic [2:0] RED    = 3'd4;
    localparam logic [2:0] PURPLE = 3'd5;
    localparam logic [2:0] YELLOW = 3'd6;
    localparam logic [2:0] WHITE  = 3'd7;

endpackage

// File: rtl/patt_gen_multi_if.sv
// Pixel bus between the sync/timing counters and the pattern generator.
// master: timing side drives pixel position, mode and controls; reads colour.
// slave: pattern generator; reads position/controls, drives rgb_o/valid_o/frame_cnt_o.
interface patt_gen_multi_if #(
    parameter int ROW_W = 9,
    parameter int COL_W = 10,
    parameter int CH_W  = 1
);
    logic               valid_i;
    logic [ROW_W-1:0]   row_i;
    logic [COL_W-1:0]   colum_i;
    logic [2:0]         mode_i;
    logic [2:0]         solid_i;
    logic               freeze_i;
    logic [3*CH_W-1:0]  rgb_o;
    logic               valid_o;
    logic [7:0]         frame_cnt_o;

    modport master (
        output valid_i, row_i, colum_i, mode_i, solid_i, freeze_i,
        input  rgb_o, valid_o, frame_cnt_o
    );

    modport slave (
        input  valid_i, row_i, colum_i, mode_i, solid_i, freeze_i,
        output rgb_o, valid_o, frame_cnt_o
    );
endinterface

// File: rtl/patt_scroll_ctrl.sv
// Frame-boundary state: end-of-frame detect, latched pattern mode, scroll offset, frame counter.
// Ports: clk_i/rst_ni, pixel position + valid, requested mode, freeze; outputs mode_q, offset_q, frame_cnt_o.
// All state changes only on the last active pixel, so it is stable for the whole following frame.
module patt_scroll_ctrl
    import patt_pkg::*;
#(
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int ROW_W       = 9,
    parameter int COL_W       = 10,
    parameter int SCROLL_STEP = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [ROW_W-1:0] row_i,
    input  logic [COL_W-1:0] colum_i,
    input  logic [2:0]       mode_i,
    input  logic             freeze_i,
    output logic [2:0]       mode_q,
    output logic [COL_W-1:0] offset_q,
    output logic [7:0]       frame_cnt_o
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACT - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACT - 1);
    localparam logic [COL_W:0]   H_ACT_X  = (COL_W+1)'(H_ACT);
    localparam logic [COL_W:0]   STEP_X   = (COL_W+1)'(SCROLL_STEP);

    logic             eof;
    logic [COL_W:0]   off_sum;
    logic [COL_W-1:0] off_nxt;

    always_comb begin
        eof     = valid_i && (row_i == ROW_LAST) && (colum_i == COL_LAST);
        // offset_q < H_ACT and STEP < H_ACT, so one conditional subtract wraps it.
        off_sum = {1'b0, offset_q} + STEP_X;
        off_nxt = COL_W'((off_sum >= H_ACT_X) ? (off_sum - H_ACT_X) : off_sum);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q      <= MODE_HBARS;
            offset_q    <= '0;
            frame_cnt_o <= '0;
        end else if (eof) begin
            mode_q      <= mode_i;
            frame_cnt_o <= frame_cnt_o + 8'd1;
            if (!freeze_i) begin
                offset_q <= off_nxt;
            end
        end
    end

endmodule

// File: rtl/patt_gen_multi.sv
// Video test-pattern generator: HBARS, VBARS, CHECKER, SCROLL, SOLID; reserved modes render black.
// Ports: clk_i/rst_ni plus a patt_gen_multi_if slave carrying pixel position/controls and colour out.
// Latency 1 cycle (registered rgb_o/valid_o); no backpressure, one pixel accepted every clock.
module patt_gen_multi
    import patt_pkg::*;
#(
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int ROW_W       = 9,
    parameter int COL_W       = 10,
    parameter int CH_W        = 1,
    parameter int CHECK_LOG2  = 5,
    parameter int SCROLL_STEP = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    patt_gen_multi_if.slave bus
);

    localparam int BH = V_ACT / 8;
    localparam int BW = H_ACT / 8;

    localparam logic [ROW_W-1:0] BH_R    = ROW_W'(BH);
    localparam logic [COL_W-1:0] BW_R    = COL_W'(BW);
    localparam logic [ROW_W-1:0] V_ACT_R = ROW_W'(V_ACT);
    localparam logic [COL_W-1:0] H_ACT_R = COL_W'(H_ACT);
    localparam logic [COL_W:0]   H_ACT_X = (COL_W+1)'(H_ACT);

    logic [2:0]        mode_q;
    logic [COL_W-1:0]  offset_q;
    logic [7:0]        frame_cnt;

    logic [COL_W:0]    scr_sum;
    logic [COL_W-1:0]  scr_col;
    logic              chk;
    logic              in_range;
    logic [2:0]        code;
    logic [3*CH_W-1:0] rgb_nxt;

    patt_scroll_ctrl #(
        .H_ACT      (H_ACT),
        .V_ACT      (V_ACT),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W),
        .SCROLL_STEP(SCROLL_STEP)
    ) u_scroll_ctrl (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (bus.valid_i),
        .row_i      (bus.row_i),
        .colum_i    (bus.colum_i),
        .mode_i     (bus.mode_i),
        .freeze_i   (bus.freeze_i),
        .mode_q     (mode_q),
        .offset_q   (offset_q),
        .frame_cnt_o(frame_cnt)
    );

    assign bus.frame_cnt_o = frame_cnt;

    always_comb begin
        // Both operands are below H_ACT when in range; out-of-range pixels are blanked below.
        scr_sum  = {1'b0, bus.colum_i} + {1'b0, offset_q};
        scr_col  = COL_W'((scr_sum >= H_ACT_X) ? (scr_sum - H_ACT_X) : scr_sum);
        chk      = 1'(bus.row_i >> CHECK_LOG2) ^ 1'(bus.colum_i >> CHECK_LOG2);
        in_range = (bus.row_i < V_ACT_R) && (bus.colum_i < H_ACT_R);

        code = BLACK;
        case (mode_q)
            MODE_HBARS:   code = 3'(bus.row_i / BH_R);
            MODE_VBARS:   code = 3'(bus.colum_i / BW_R);
            MODE_CHECKER: code = chk ? WHITE : BLACK;
            MODE_SCROLL:  code = 3'(scr_col / BW_R);
            MODE_SOLID:   code = bus.solid_i;
            default:      code = BLACK;
        endcase

        rgb_nxt = {{CH_W{code[2]}}, {CH_W{code[1]}}, {CH_W{code[0]}}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rgb_o   <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            bus.rgb_o   <= (bus.valid_i && in_range) ? rgb_nxt : '0;
            bus.valid_o <= bus.valid_i;
        end
    end

endmodule

// File: tb/tb_patt_gen_multi.sv
// Randomized + directed bench for patt_gen_multi with a queue scoreboard and an arithmetic reference model.
// The driver issues one pixel per clock and pushes the expected response; a negedge monitor pops and compares.
// Frame ends are produced by driving the last active pixel directly, so no full frames are scanned.
module tb_patt_gen_multi;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int ROW_W = 9;
    localparam int COL_W = 10;
    localparam int CH_W  = 1;

    typedef struct {
        logic       vld;
        logic [2:0] rgb;
        logic [7:0] fcnt;
        string      tag;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t q[$];
    int   n_tests;
    int   n_fail;

    // reference model state
    int m_mode;
    int m_off;
    int m_fcnt;

    patt_gen_multi_if #(.ROW_W(ROW_W), .COL_W(COL_W), .CH_W(CH_W)) bus ();

    patt_gen_multi #(
        .H_ACT(H_ACT), .V_ACT(V_ACT), .ROW_W(ROW_W), .COL_W(COL_W),
        .CH_W(CH_W), .CHECK_LOG2(5), .SCROLL_STEP(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model_code(int row, int col, int mode, int off, logic [2:0] solid);
        if (row >= V_ACT || col >= H_ACT) return 3'd0;
        case (mode)
            0: return 3'(row / (V_ACT / 8));
            1: return 3'(col / (H_ACT / 8));
            2: return (((row / 32) + (col / 32)) % 2 == 1) ? 3'd7 : 3'd0;
            3: return 3'(((col + off) % H_ACT) / (H_ACT / 8));
            4: return solid;
            default: return 3'd0;
        endcase
    endfunction

    task automatic chk(string name, int got, int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic pix(int row, int col, logic vld, logic [2:0] mode, logic [2:0] solid,
                       logic frz, string tag);
        exp_t e;
        bit   eof;
        bus.valid_i  = vld;
        bus.row_i    = ROW_W'(row);
        bus.colum_i  = COL_W'(col);
        bus.mode_i   = mode;
        bus.solid_i  = solid;
        bus.freeze_i = frz;
        e.vld = vld;
        e.rgb = vld ? model_code(row, col, m_mode, m_off, solid) : 3'd0;
        eof   = vld && (row == V_ACT - 1) && (col == H_ACT - 1);
        if (eof) begin
            m_mode = int'(mode);
            m_fcnt = (m_fcnt + 1) % 256;
            if (!frz) m_off = (m_off + 16) % H_ACT;
        end
        e.fcnt = 8'(m_fcnt);
        e.tag  = tag;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    task automatic eof_pix(logic [2:0] mode, logic frz);
        pix(V_ACT - 1, H_ACT - 1, 1'b1, mode, 3'd0, frz, "eof");
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries still queued, expected 0", q.size());
            q.delete();
        end
    endtask

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_tests++;
                if (bus.valid_o !== e.vld || bus.rgb_o !== e.rgb || bus.frame_cnt_o !== e.fcnt) begin
                    n_fail++;
                    $display("FAIL %s: got vld=%b rgb=%b fcnt=%0d, expected vld=%b rgb=%b fcnt=%0d",
                             e.tag, bus.valid_o, bus.rgb_o, bus.frame_cnt_o, e.vld, e.rgb, e.fcnt);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_mode  = 0;
        m_off   = 0;
        m_fcnt  = 0;
        rst_n        = 1'b0;
        bus.valid_i  = 1'b0;
        bus.row_i    = '0;
        bus.colum_i  = '0;
        bus.mode_i   = 3'd0;
        bus.solid_i  = 3'd0;
        bus.freeze_i = 1'b0;

        #12;
        chk("reset_rgb", int'(bus.rgb_o), 0);
        chk("reset_valid", int'(bus.valid_o), 0);
        chk("reset_fcnt", int'(bus.frame_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // HBARS after reset
        pix(130, 5, 1'b1, 3'd0, 3'd0, 1'b0, "hbars_130_5");
        // mode request mid-frame is ignored until the frame end
        pix(0, 250, 1'b1, 3'd1, 3'd0, 1'b0, "vbars_pending");
        eof_pix(3'd1, 1'b0);
        pix(0, 250, 1'b1, 3'd0, 3'd0, 1'b0, "vbars_0_250");
        // CHECKER
        eof_pix(3'd2, 1'b0);
        pix(40, 10, 1'b1, 3'd0, 3'd0, 1'b0, "checker_40_10");
        pix(40, 40, 1'b1, 3'd0, 3'd0, 1'b0, "checker_40_40");
        // SCROLL with advancing, then frozen, offset
        for (int i = 0; i < 5; i++) eof_pix(3'd3, 1'b0);
        pix(0, 0, 1'b1, 3'd0, 3'd0, 1'b0, "scroll_col0");
        pix(0, 600, 1'b1, 3'd0, 3'd0, 1'b0, "scroll_col600");
        pix(0, 639, 1'b1, 3'd0, 3'd0, 1'b0, "scroll_col639");
        eof_pix(3'd3, 1'b1);
        pix(0, 600, 1'b1, 3'd0, 3'd0, 1'b0, "scroll_frozen");
        // SOLID and reserved
        eof_pix(3'd4, 1'b0);
        pix(10, 10, 1'b1, 3'd0, 3'd5, 1'b0, "solid_5");
        eof_pix(3'd6, 1'b0);
        pix(10, 10, 1'b1, 3'd0, 3'd5, 1'b0, "reserved_6");
        // blanking and out-of-range
        eof_pix(3'd7, 1'b0);
        eof_pix(3'd0, 1'b0);
        pix(10, 10, 1'b0, 3'd0, 3'd0, 1'b0, "blank");
        pix(500, 10, 1'b1, 3'd0, 3'd0, 1'b0, "row_oor");
        pix(10, 700, 1'b1, 3'd0, 3'd0, 1'b0, "col_oor");
        // the eof pixel itself rendered with the old mode
        pix(V_ACT - 1, H_ACT - 1, 1'b1, 3'd2, 3'd0, 1'b0, "eof_old_mode");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int   r;
            int   row;
            int   col;
            logic vld;
            r   = int'($urandom_range(0, 39));
            vld = ($urandom_range(0, 9) != 0);
            if (r == 0) begin
                row = V_ACT - 1;
                col = H_ACT - 1;
            end else begin
                row = int'($urandom_range(0, 511));
                col = (r < 36) ? int'($urandom_range(0, H_ACT - 1)) : int'($urandom_range(0, 1023));
                if (row > 500 && r < 30) row = row - 40;
            end
            pix(row, col, vld, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) == 0), "random");
        end

        // frame counter wrap
        for (int i = 0; i < 256; i++) eof_pix(3'd3, 1'b0);
        pix(0, 0, 1'b1, 3'd0, 3'd0, 1'b0, "after_wrap");

        // asynchronous reset mid-frame in SCROLL mode
        eof_pix(3'd3, 1'b0);
        pix(100, 300, 1'b1, 3'd0, 3'd0, 1'b0, "pre_reset");
        wait_drain();
        rst_n = 1'b0;
        #1;
        chk("async_rst_rgb", int'(bus.rgb_o), 0);
        chk("async_rst_valid", int'(bus.valid_o), 0);
        chk("async_rst_fcnt", int'(bus.frame_cnt_o), 0);
        m_mode = 0;
        m_off  = 0;
        m_fcnt = 0;
        #1;
        rst_n = 1'b1;
        pix(130, 5, 1'b1, 3'd3, 3'd0, 1'b0, "post_reset_hbars");
        pix(0, 0, 1'b1, 3'd3, 3'd0, 1'b0, "post_reset_row0");

        wait_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
